// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared constants, fetch FSM encoding and FIFO entry type.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    localparam logic [1:0] FETCH_IDLE = 2'd0;
    localparam logic [1:0] FETCH_REQ  = 2'd1;
    localparam logic [1:0] FETCH_DROP = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = FETCH_IDLE,
        ST_REQ  = FETCH_REQ,
        ST_DROP = FETCH_DROP
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus_4;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Brief    : Synchronous FIFO of {instr, pc_plus_4}; flush beats push and pop.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             wdata,
    output fetch_entry_t             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign w_do_push = push && !flush;
    assign w_do_pop  = pop && !flush && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= wdata;
    end

    assign rdata = r_mem[r_rd_ptr];
    assign full  = (r_count == DEPTH_C);
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_unit
// Brief    : IF stage: PC, single-outstanding imem fetch FSM, buffered output.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        IF_ID_write,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        oValid,
    output logic [31:0] oInstruction,
    output logic [31:0] oPC_plus_4
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

    fetch_state_t  r_state;
    fetch_state_t  w_next_state;
    logic [31:0]   r_pc;
    logic [31:0]   r_addr;
    logic [31:0]   w_redirect_target;
    logic          w_issue;
    logic          w_push;
    logic          w_pop;
    logic          w_room;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    fetch_entry_t  w_wdata;
    fetch_entry_t  w_head;

    assign w_redirect_target = redirect_pc & 32'hFFFF_FFFC;
    assign w_room            = (w_count < DEPTH_C);
    assign w_pop             = oValid && IF_ID_write && !redirect;
    assign w_wdata           = '{instr: imem_rdata, pc_plus_4: r_addr + 32'd4};

    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        w_push       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!redirect && w_room) begin
                    w_next_state = ST_REQ;
                    w_issue      = 1'b1;
                end
            end
            ST_REQ: begin
                if (imem_ack) begin
                    w_next_state = ST_IDLE;
                    w_push       = !redirect;
                end else if (redirect) begin
                    // The request cannot be withdrawn; swallow its response later
                    w_next_state = ST_DROP;
                end
            end
            ST_DROP: begin
                if (imem_ack) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
            r_addr  <= RESET_PC;
        end else begin
            r_state <= w_next_state;
            if (redirect)    r_pc <= w_redirect_target;
            else if (w_push) r_pc <= r_pc + 32'd4;
            if (w_issue)     r_addr <= r_pc;
        end
    end

    fetch_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (w_push),
        .pop   (w_pop),
        .flush (redirect),
        .wdata (w_wdata),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    assign imem_req     = (r_state != ST_IDLE);
    assign imem_addr    = r_addr;
    assign oValid       = !w_empty;
    assign oInstruction = w_empty ? NOP_INSTR : w_head.instr;
    assign oPC_plus_4   = w_empty ? RESET_PC  : w_head.pc_plus_4;

    a_no_push_when_full: assert property (@(posedge clk) disable iff (reset) !(w_push && w_full));

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_unit
// Brief    : Directed bench with a queue-based fetch-stream model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;

    localparam logic [31:0] RPC   = 32'h8000_0000;
    localparam int          DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        IF_ID_write = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        oValid;
    logic [31:0] oInstruction;
    logic [31:0] oPC_plus_4;

    if_fetch_unit #(
        .RESET_PC  (RPC),
        .BUF_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .IF_ID_write  (IF_ID_write),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .oValid       (oValid),
        .oInstruction (oInstruction),
        .oPC_plus_4   (oPC_plus_4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } ent_t;

    int          checks = 0;
    int          failures = 0;
    ent_t        mq[$];
    logic [31:0] log_q[$];
    logic        m_out;
    logic        m_stale;
    logic [31:0] m_addr;
    logic [31:0] m_pc;
    int          lat = 0;
    int          age = 0;
    bit          wr_en = 0;
    bit          arm_redir = 0;
    bit          arm_need_valid = 0;
    bit          redir_now = 0;
    logic [31:0] redir_target = 32'h0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic chk_log(input string name, input int idx, input logic [31:0] exp);
        if (idx >= log_q.size()) begin
            checks++;
            failures++;
            $display("FAIL %s: got %0d accepted words expected more than %0d", name, log_q.size(), idx);
        end else begin
            chk(name, log_q[idx], exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        log_q.delete();
        m_out   = 1'b0;
        m_stale = 1'b0;
        m_addr  = RPC;
        m_pc    = RPC;
    endtask

    // Fetch stream at transaction level: one outstanding fetch, FIFO as a queue
    task automatic model_step(input logic rd, input logic [31:0] rpc, input logic wr, input logic ack);
        int n;
        bit pop;
        n   = mq.size();
        pop = (n > 0) && wr && !rd;
        if (rd) begin
            mq.delete();
            m_pc = rpc & 32'hFFFF_FFFC;
            if (m_out && ack) begin
                m_out   = 1'b0;
                m_stale = 1'b0;
            end else if (m_out) begin
                m_stale = 1'b1;
            end
        end else begin
            if (pop) void'(mq.pop_front());
            if (m_out && ack) begin
                if (!m_stale) begin
                    mq.push_back('{instr_of(m_addr), m_addr + 32'd4});
                    m_pc = m_addr + 32'd4;
                end
                m_out   = 1'b0;
                m_stale = 1'b0;
            end else if (!m_out && n < DEPTH) begin
                m_out   = 1'b1;
                m_addr  = m_pc;
                m_stale = 1'b0;
            end
        end
    endtask

    task automatic cyc();
        logic ack;
        logic fire;
        @(negedge clk);
        chk("imem_req", {31'b0, imem_req}, {31'b0, m_out});
        if (m_out) chk("imem_addr", imem_addr, m_addr);
        chk("oValid", {31'b0, oValid}, {31'b0, (mq.size() > 0)});
        if (mq.size() > 0) begin
            chk("oInstruction", oInstruction, mq[0].instr);
            chk("oPC_plus_4", oPC_plus_4, mq[0].pc4);
        end else begin
            chk("oInstruction_bubble", oInstruction, 32'h0);
            chk("oPC_plus_4_bubble", oPC_plus_4, RPC);
        end
        fire = redir_now || (arm_redir && imem_req && (!arm_need_valid || oValid));
        ack  = imem_req && (age >= lat);
        if (!imem_req || ack) age = 0;
        else                  age++;
        redirect    = fire;
        IF_ID_write = wr_en || (fire && arm_need_valid);
        if (fire) begin
            redirect_pc = redir_target;
            redir_now   = 0;
            arm_redir   = 0;
            log_q.delete();
        end
        imem_ack   = ack;
        imem_rdata = ack ? instr_of(imem_addr) : 32'hDEAD_BEEF;
        if (oValid && IF_ID_write && !redirect) log_q.push_back(oPC_plus_4);
        model_step(redirect, redirect_pc, IF_ID_write, ack);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        redirect = 1'b0;
        imem_ack = 1'b0;
        IF_ID_write = 1'b0;
        arm_redir = 0;
        arm_need_valid = 0;
        redir_now = 0;
        age = 0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_step(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_imem_req"}, {31'b0, imem_req}, 32'h0);
        chk({tag, "_imem_addr"}, imem_addr, 32'h8000_0000);
        chk({tag, "_oValid"}, {31'b0, oValid}, 32'h0);
        chk({tag, "_oInstruction"}, oInstruction, 32'h0);
        chk({tag, "_oPC_plus_4"}, oPC_plus_4, 32'h8000_0000);
    endtask

    task automatic wait_fired(input string name);
        for (int i = 0; i < 20 && (arm_redir || redir_now); i++) cyc();
        chk(name, {31'b0, (arm_redir || redir_now)}, 32'h0);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        chk_reset_values("reset");
        do_reset();

        // Free-running stream with one-cycle memory latency
        wr_en = 1; lat = 1;
        repeat (30) cyc();
        chk_log("t1_pc4_0", 0, 32'h8000_0004);
        chk_log("t1_pc4_1", 1, 32'h8000_0008);
        chk_log("t1_pc4_2", 2, 32'h8000_000C);
        chk_log("t1_pc4_3", 3, 32'h8000_0010);

        // Backpressure: buffer fills, request stops, head holds
        do_reset();
        wr_en = 0; lat = 1;
        repeat (10) cyc();
        chk("t2_req_low", {31'b0, imem_req}, 32'h0);
        chk("t2_valid", {31'b0, oValid}, 32'h1);
        chk("t2_head_pc4", oPC_plus_4, 32'h8000_0004);
        chk("t2_head_instr", oInstruction, instr_of(32'h8000_0000));
        wr_en = 1;
        repeat (20) cyc();
        chk_log("t2_resume_0", 0, 32'h8000_0004);
        chk_log("t2_resume_1", 1, 32'h8000_0008);
        chk_log("t2_resume_2", 2, 32'h8000_000C);

        // Redirect during an outstanding request; its response must vanish
        lat = 3; redir_target = 32'h8000_0100; arm_redir = 1;
        wait_fired("t3_redirect_fired");
        repeat (20) cyc();
        chk_log("t3_first_pc4", 0, 32'h8000_0104);
        chk_log("t3_second_pc4", 1, 32'h8000_0108);

        // Redirect coincident with ack while a word is presented and accepted
        do_reset();
        wr_en = 0; lat = 0; redir_target = 32'h8000_0200;
        arm_need_valid = 1; arm_redir = 1;
        wait_fired("t4_redirect_fired");
        arm_need_valid = 0;
        cyc();
        chk("t4_valid", {31'b0, oValid}, 32'h0);
        chk("t4_instr", oInstruction, 32'h0);
        chk("t4_req", {31'b0, imem_req}, 32'h0);

        // Wrap at the top of the address space, low target bits ignored
        wr_en = 1; lat = 0; redir_target = 32'hFFFF_FFFF; redir_now = 1;
        wait_fired("t5_redirect_fired");
        repeat (15) cyc();
        chk_log("t5_wrap_0", 0, 32'h0000_0000);
        chk_log("t5_wrap_1", 1, 32'h0000_0004);

        // Asynchronous reset while a dropped response is still pending
        lat = 6; redir_target = 32'h8000_0300; arm_redir = 1;
        wait_fired("t6_redirect_fired");
        cyc();
        chk("t6_drop_req_held", {31'b0, imem_req}, 32'h1);
        #2 reset = 1'b1;
        #1 chk_reset_values("t6_async");
        do_reset();
        wr_en = 1; lat = 0;
        repeat (10) cyc();
        chk_log("t6_first_pc4", 0, 32'h8000_0004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
